fir_coef_loader: RTL and testbench

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

---
 rtl/fir_coef_loader.sv | 144 ++++++++++++++
 tb/tb_fir_coef_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// Streams NUM_WORDS coefficient words into a filter coefficient memory while
// holding the filter quiet; handles arm/flush quiesce windows, timeout and abort.
module fir_coef_loader #(
  parameter int unsigned NUM_WORDS    = 2048,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_req,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [19:0] s_data,
  output logic        s_ready,
  output logic [19:0] CIN,
  output logic [10:0] CADDR,
  output logic        CLOAD,
  output logic        filter_hold,
  output logic        busy,
  output logic        load_done,
  output logic        err,
  output logic [11:0] wr_count
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    FLUSH,
    DONE
  } state_e;

  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [11:0] LAST_WORD  = 12'(NUM_WORDS);

  state_e      state_q;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] wr_count_q, wr_count_d;
  logic [19:0] cin_q;
  logic [10:0] caddr_q;
  logic        cload_q, hold_q, busy_q, done_q, err_q;
  logic        accept;

  assign s_ready = (state_q == LOAD);

  always_comb begin
    accept     = s_valid & s_ready;
    cnt_d      = cnt_q + 16'd1;
    wr_count_d = wr_count_q + 12'd1;
  end

  // cnt_q is shared: hold window in ARM, idle timer in LOAD, flush window in FLUSH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_count_q <= '0;
      cin_q      <= '0;
      caddr_q    <= '0;
      cload_q    <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cload_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != IDLE && abort) begin
        // Abort outranks any accept, timeout or completion in the same cycle.
        state_q <= IDLE;
        hold_q  <= 1'b0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_req) begin
              state_q    <= ARM;
              wr_count_q <= '0;
              err_q      <= 1'b0;
              hold_q     <= 1'b1;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
            end
          end
          ARM: begin
            if (cnt_q == HOLD_LAST) begin
              state_q <= LOAD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          LOAD: begin
            if (accept) begin
              cload_q    <= 1'b1;
              cin_q      <= s_data;
              caddr_q    <= wr_count_q[10:0];
              wr_count_q <= wr_count_d;
              cnt_q      <= '0;
              if (wr_count_d == LAST_WORD) state_q <= FLUSH;
            end else if (cnt_q == TO_LAST) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
              hold_q  <= 1'b0;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          DONE: begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign CIN         = cin_q;
  assign CADDR       = caddr_q;
  assign CLOAD       = cload_q;
  assign filter_hold = hold_q;
  assign busy        = busy_q;
  assign load_done   = done_q;
  assign err         = err_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: expected writes are queued at stimulus time
// and a negedge monitor pops them against every CLOAD strobe (value and cycle).
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        resetn, load_req, abort, s_valid;
  logic [19:0] s_data;
  logic        s_ready, CLOAD, filter_hold, busy, load_done, err;
  logic [19:0] CIN;
  logic [10:0] CADDR;
  logic [11:0] wr_count;

  typedef struct {
    logic [10:0] addr;
    logic [19:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         sb[$];
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int          tests    = 0;
  int          failed   = 0;

  fir_coef_loader #(
    .NUM_WORDS   (4),
    .HOLD_CYCLES (4),
    .FLUSH_CYCLES(4),
    .TIMEOUT     (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_req   (load_req),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .filter_hold(filter_hold),
    .busy       (busy),
    .load_done  (load_done),
    .err        (err),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (load_done === 1'b1) done_cnt++;
    if (CLOAD !== 1'b0) begin
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL cload_unexpected: got addr %0h data %0h at cycle %0d, required no write",
                 CADDR, CIN, cyc);
      end else begin
        e = sb.pop_front();
        if (CADDR !== e.addr || CIN !== e.data || cyc != e.cyc) begin
          failed++;
          $display("FAIL cload_word: got addr %0h data %0h cycle %0d, required addr %0h data %0h cycle %0d",
                   CADDR, CIN, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Inputs are driven just after a negedge, so the accept lands on the next posedge
  // and its CLOAD is seen by the monitor one cycle later.
  task automatic push(input logic [10:0] addr, input logic [19:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic send(input logic [10:0] addr, input logic [19:0] data);
    s_valid = 1'b1;
    s_data  = data;
    push(addr, data);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("arm_hold_high", filter_hold, 1);
    check("arm_err_clear", err, 0);
    check("arm_wrcnt_clear", wr_count, 0);
    for (int i = 0; i < 4; i++) begin
      check("arm_not_ready", s_ready, 0);
      tick();
    end
    check("load_ready", s_ready, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (load_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("done_within_budget", load_done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cin"}, CIN, 0);
    check({tag, "_caddr"}, CADDR, 0);
    check({tag, "_cload"}, CLOAD, 0);
    check({tag, "_hold"}, filter_hold, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_wrcnt"}, wr_count, 0);
    check({tag, "_ready"}, s_ready, 0);
  endtask

  initial begin
    resetn = 1'b0; load_req = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    tick();
    tick();
    check_all_zero("reset");
    resetn = 1'b1;
    tick();

    // Back-to-back load of four words
    start_load();
    for (int i = 0; i < 4; i++) send(11'(i), 20'h00011 + 20'(i));
    check("flush_not_ready", s_ready, 0);
    check("flush_wrcnt", wr_count, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_done", load_done, 0);
    end
    tick();
    check("done_pulse", load_done, 1);
    check("done_hold_still_high", filter_hold, 1);
    tick();
    check("after_done_low", load_done, 0);
    check("after_done_hold", filter_hold, 0);
    check("after_done_busy", busy, 0);
    check("after_done_wrcnt", wr_count, 4);
    check("hold_caddr", CADDR, 3);
    check("hold_cin", CIN, 20'h00014);
    check("done_count_1", done_cnt, 1);

    // Toggling s_valid, plus load_req in LOAD and in FLUSH
    start_load();
    for (int i = 0; i < 8; i++) begin
      load_req = (i == 1);
      if (i % 2 == 0) begin
        s_valid = 1'b1;
        s_data  = 20'h00021 + 20'(i / 2);
        push(11'(i / 2), s_data);
      end else begin
        s_valid = 1'b0;
      end
      tick();
    end
    s_valid  = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    wait_done();
    tick();
    tick();
    check("toggle_busy_idle", busy, 0);
    check("toggle_wrcnt", wr_count, 4);
    check("done_count_2", done_cnt, 2);

    // Timeout with s_valid held low
    start_load();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) check("timeout_err_pending", err, 0);
    end
    check("timeout_err_set", err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_hold", filter_hold, 0);
    tick();
    check("timeout_no_done", done_cnt, 2);

    // Next load clears err; abort on the third accept
    start_load();
    send(11'd0, 20'h00031);
    send(11'd1, 20'h00032);
    s_valid = 1'b1;
    s_data  = 20'h00033;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    check("abort_hold", filter_hold, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", s_ready, 0);
    check("abort_wrcnt", wr_count, 2);
    check("abort_err", err, 0);
    check("abort_no_cload", CLOAD, 0);
    tick();
    tick();
    check("abort_no_done", done_cnt, 2);

    // Reset in the middle of a load
    start_load();
    send(11'd0, 20'h00041);
    send(11'd1, 20'h00042);
    check("pre_reset_wrcnt", wr_count, 2);
    s_valid = 1'b1;
    s_data  = 20'h00043;
    resetn  = 1'b0;
    #1;
    check_all_zero("async_reset");
    s_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    start_load();
    for (int i = 0; i < 4; i++) send(11'(i), 20'h00051 + 20'(i));
    wait_done();
    tick();
    check("done_count_final", done_cnt, 3);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
